mem_port_arbiter: RTL and testbench

Shares one single-ported unified memory between the instruction-fetch stage and the data-memory (load/store) stage of the 5-stage RISC-V pipeline. It accepts one request at a time and drives a registered request to memory. It returns registered read data and a completion pulse to the owning requester, and raises per-stage stall signals that the pipeline control logic uses to freeze IF/ID or EX/MEM. By default data accesses have priority over fetches, with an optional anti-starvation guard.

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_port_arbiter_starve_guard.sv | 33 +++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/DM memory port arbiter: FSM state encoding and the
// registered memory request bundle.
package common;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_BUSY_IF = 2'd1,
      ARB_BUSY_DM = 2'd2
   } arb_state_type;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_req_type;

   localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_starve_guard.sv
// Anti-starvation counter for the memory port arbiter: counts data grants made
// while a fetch waits and forces one fetch grant once the limit is reached.
module arb_starve_guard #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic arb_cycle,
   input  logic if_req,
   input  logic grant_if,
   input  logic grant_dm,
   output logic force_if
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_cnt;

   assign force_if = (starve_cnt == LIMIT);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         starve_cnt <= 4'd0;
      end else if (arb_cycle) begin
         if (grant_if || !if_req) begin
            starve_cnt <= 4'd0;
         end else if (grant_dm && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store stages.
// Define ARB_STARVE_GUARD_EN to build in the fetch anti-starvation guard.
module mem_port_arbiter
   import common::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          if_req,
   input  logic [31:0]   if_addr,
   output logic          if_rvalid,
   output logic [31:0]   if_rdata,
   output logic          if_stall,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [31:0]   dm_addr,
   input  logic [31:0]   dm_wdata,
   input  logic [3:0]    dm_be,
   output logic          dm_rvalid,
   output logic [31:0]   dm_rdata,
   output logic          dm_stall,
   output logic          mem_req,
   output logic          mem_we,
   output logic [31:0]   mem_addr,
   output logic [31:0]   mem_wdata,
   output logic [3:0]    mem_be,
   input  logic          mem_ack,
   input  logic [31:0]   mem_rdata,
   output arb_state_type dbg_state
);

   arb_state_type state;
   mem_req_type   mem_q;
   logic          arb_cycle;
   logic          if_elig;
   logic          dm_elig;
   logic          force_if;
   logic          grant_if;
   logic          grant_dm;

   // Valid/ready: a requester holds req and its fields until its rvalid pulse;
   // rvalid is the one-cycle acceptance, and req seen in that cycle is the old one.
   assign if_elig  = if_req & ~if_rvalid;
   assign dm_elig  = dm_req & ~dm_rvalid;
   assign if_stall = if_req & ~if_rvalid;
   assign dm_stall = dm_req & ~dm_rvalid;

   // The completion cycle is a turnaround: nothing is granted while an rvalid
   // pulses, so the served stage can renew its request against the other one.
   assign arb_cycle = (state == ARB_IDLE) & ~if_rvalid & ~dm_rvalid;
   assign grant_dm  = arb_cycle & dm_elig & ~(force_if & if_elig);
   assign grant_if  = arb_cycle & if_elig & ~grant_dm;

`ifdef ARB_STARVE_GUARD_EN
   arb_starve_guard #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve_guard (
      .clk       (clk),
      .reset_n   (reset_n),
      .arb_cycle (arb_cycle),
      .if_req    (if_req),
      .grant_if  (grant_if),
      .grant_dm  (grant_dm),
      .force_if  (force_if)
   );
`else
   logic unused_limit;
   assign unused_limit = ^STARVE_LIMIT[3:0];
   assign force_if     = 1'b0;
`endif

   assign mem_we    = mem_q.we;
   assign mem_be    = mem_q.be;
   assign mem_addr  = mem_q.addr;
   assign mem_wdata = mem_q.wdata;
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= ARB_IDLE;
         mem_req   <= 1'b0;
         mem_q     <= '0;
         if_rvalid <= 1'b0;
         dm_rvalid <= 1'b0;
         if_rdata  <= 32'd0;
         dm_rdata  <= 32'd0;
      end else begin
         if_rvalid <= 1'b0;
         dm_rvalid <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (grant_dm) begin
                  mem_q.we    <= dm_we;
                  mem_q.be    <= dm_be;
                  mem_q.addr  <= dm_addr;
                  mem_q.wdata <= dm_wdata;
                  mem_req     <= 1'b1;
                  state       <= ARB_BUSY_DM;
               end else if (grant_if) begin
                  mem_q.we    <= 1'b0;
                  mem_q.be    <= FETCH_BE;
                  mem_q.addr  <= if_addr;
                  mem_req     <= 1'b1;
                  state       <= ARB_BUSY_IF;
               end
            end
            ARB_BUSY_IF: begin
               if (mem_ack) begin
                  mem_req   <= 1'b0;
                  state     <= ARB_IDLE;
                  if_rvalid <= 1'b1;
                  if_rdata  <= mem_rdata;
               end
            end
            ARB_BUSY_DM: begin
               if (mem_ack) begin
                  mem_req   <= 1'b0;
                  state     <= ARB_IDLE;
                  dm_rvalid <= 1'b1;
                  if (!mem_q.we) begin
                     dm_rdata <= mem_rdata;
                  end
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, contention, delayed store,
// and grant order under continuous data traffic (guard on or off).
module tb_mem_port_arbiter;
   import common::*;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          if_req;
   logic [31:0]   if_addr;
   logic          if_rvalid;
   logic [31:0]   if_rdata;
   logic          if_stall;
   logic          dm_req;
   logic          dm_we;
   logic [31:0]   dm_addr;
   logic [31:0]   dm_wdata;
   logic [3:0]    dm_be;
   logic          dm_rvalid;
   logic [31:0]   dm_rdata;
   logic          dm_stall;
   logic          mem_req;
   logic          mem_we;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_be;
   logic          mem_ack;
   logic [31:0]   mem_rdata;
   arb_state_type dbg_state;

   int checks = 0;
   int failures = 0;
   int if_pulses = 0;
   int dm_pulses = 0;
   logic [1:0] exp_q[$];
   logic [1:0] got_q[$];

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .STARVE_LIMIT (2)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .if_stall  (if_stall),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_be     (dm_be),
      .dm_rvalid (dm_rvalid),
      .dm_rdata  (dm_rdata),
      .dm_stall  (dm_stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .dbg_state (dbg_state)
   );

   // Memory contents: one fixed instruction word, everything else addr-derived.
   always_comb begin
      mem_rdata = mem_addr ^ 32'h5A5A_0000;
      if (mem_addr == 32'h10) mem_rdata = 32'h00A0_0093;
   end

   always @(posedge clk) begin
      if_pulses <= if_pulses + int'(if_rvalid);
      dm_pulses <= dm_pulses + int'(dm_rvalid);
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_mem_req"},   32'(mem_req),   32'h0);
      check_eq({tag, "_mem_we"},    32'(mem_we),    32'h0);
      check_eq({tag, "_mem_addr"},  mem_addr,       32'h0);
      check_eq({tag, "_mem_wdata"}, mem_wdata,      32'h0);
      check_eq({tag, "_mem_be"},    32'(mem_be),    32'h0);
      check_eq({tag, "_if_rvalid"}, 32'(if_rvalid), 32'h0);
      check_eq({tag, "_dm_rvalid"}, 32'(dm_rvalid), 32'h0);
      check_eq({tag, "_if_rdata"},  if_rdata,       32'h0);
      check_eq({tag, "_dm_rdata"},  dm_rdata,       32'h0);
      check_eq({tag, "_state"},     32'(dbg_state), 32'(ARB_IDLE));
   endtask

   initial begin
      int if_base;
      int dm_base;
      logic last_req;

      reset_n = 1'b0; if_req = 1'b0; if_addr = '0;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
      mem_ack = 1'b0;
      repeat (3) tick();
      check_reset_outputs("por");
      reset_n = 1'b1;

      // Reset while BUSY_DM, then a stale ack afterwards.
      tick();
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
      tick();
      check_eq("rst_mid_busy_state", 32'(dbg_state), 32'(ARB_BUSY_DM));
      reset_n = 1'b0; dm_req = 1'b0;
      tick();
      reset_n = 1'b1; mem_ack = 1'b1;
      tick();
      check_reset_outputs("rst_stale_ack");
      tick();
      check_eq("rst_stale_dm_rvalid", 32'(dm_rvalid), 32'h0);
      check_eq("rst_stale_mem_req", 32'(mem_req), 32'h0);
      mem_ack = 1'b0;

      // Fetch only, ack one cycle after mem_req.
      tick();
      if_base = if_pulses;
      if_req = 1'b1; if_addr = 32'h10;
      tick();
      check_eq("f_mem_req",  32'(mem_req),  32'h1);
      check_eq("f_mem_addr", mem_addr,      32'h10);
      check_eq("f_mem_we",   32'(mem_we),   32'h0);
      check_eq("f_mem_be",   32'(mem_be),   32'hF);
      check_eq("f_if_stall", 32'(if_stall), 32'h1);
      tick();
      check_eq("f_wait_mem_req", 32'(mem_req), 32'h1);
      mem_ack = 1'b1;
      tick();
      check_eq("f_if_rvalid", 32'(if_rvalid), 32'h1);
      check_eq("f_if_rdata",  if_rdata,       32'h00A0_0093);
      check_eq("f_if_stall_done", 32'(if_stall), 32'h0);
      check_eq("f_mem_req_clr", 32'(mem_req), 32'h0);
      if_req = 1'b0; mem_ack = 1'b0;
      tick();
      check_eq("f_if_rvalid_once", 32'(if_rvalid), 32'h0);
      check_eq("f_pulse_count", 32'(if_pulses - if_base), 32'd1);

      // Simultaneous fetch and load, zero-wait memory.
      if_base = if_pulses; dm_base = dm_pulses;
      if_req = 1'b1; if_addr = 32'h20;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
      mem_ack = 1'b1;
      tick();
      check_eq("sim_c1_state", 32'(dbg_state), 32'(ARB_BUSY_DM));
      check_eq("sim_c1_addr",  mem_addr,       32'h100);
      check_eq("sim_c1_if_stall", 32'(if_stall), 32'h1);
      tick();
      check_eq("sim_c2_dm_rvalid", 32'(dm_rvalid), 32'h1);
      check_eq("sim_c2_dm_rdata",  dm_rdata,       32'h5A5A_0100);
      check_eq("sim_c2_dm_stall",  32'(dm_stall),  32'h0);
      dm_req = 1'b0;
      tick();
      check_eq("sim_c3_state",   32'(dbg_state), 32'(ARB_IDLE));
      check_eq("sim_c3_mem_req", 32'(mem_req),   32'h0);
      tick();
      check_eq("sim_c4_state", 32'(dbg_state), 32'(ARB_BUSY_IF));
      check_eq("sim_c4_addr",  mem_addr,       32'h20);
      tick();
      check_eq("sim_c5_if_rvalid", 32'(if_rvalid), 32'h1);
      check_eq("sim_c5_if_rdata",  if_rdata,       32'h5A5A_0020);
      if_req = 1'b0; mem_ack = 1'b0;
      tick();
      check_eq("sim_if_pulses", 32'(if_pulses - if_base), 32'd1);
      check_eq("sim_dm_pulses", 32'(dm_pulses - dm_base), 32'd1);

      // Store with a 5-cycle ack delay; load data register must not change.
      dm_base = dm_pulses;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'h3;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq($sformatf("st_hold%0d_req", i),   32'(mem_req),  32'h1);
         check_eq($sformatf("st_hold%0d_we", i),    32'(mem_we),   32'h1);
         check_eq($sformatf("st_hold%0d_addr", i),  mem_addr,      32'h200);
         check_eq($sformatf("st_hold%0d_wdata", i), mem_wdata,     32'hDEAD_BEEF);
         check_eq($sformatf("st_hold%0d_be", i),    32'(mem_be),   32'h3);
         check_eq($sformatf("st_hold%0d_stall", i), 32'(dm_stall), 32'h1);
      end
      mem_ack = 1'b1;
      tick();
      check_eq("st_dm_rvalid", 32'(dm_rvalid), 32'h1);
      check_eq("st_dm_rdata_kept", dm_rdata,   32'h5A5A_0100);
      check_eq("st_dm_stall_done", 32'(dm_stall), 32'h0);
      dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
      tick();
      check_eq("st_dm_pulses", 32'(dm_pulses - dm_base), 32'd1);

      // Fetch after store: forced read/full-word, write data left alone.
      if_req = 1'b1; if_addr = 32'h30; mem_ack = 1'b1;
      tick();
      check_eq("fa_mem_wdata", mem_wdata,    32'hDEAD_BEEF);
      check_eq("fa_mem_we",    32'(mem_we),  32'h0);
      check_eq("fa_mem_be",    32'(mem_be),  32'hF);
      check_eq("fa_mem_addr",  mem_addr,     32'h30);
      tick();
      check_eq("fa_if_rdata", if_rdata, 32'h5A5A_0030);
      if_req = 1'b0; mem_ack = 1'b0;
      repeat (2) tick();

      // Continuous data traffic with a waiting fetch.
`ifdef ARB_STARVE_GUARD_EN
      exp_q = '{2'(ARB_BUSY_DM), 2'(ARB_BUSY_DM), 2'(ARB_BUSY_IF),
                2'(ARB_BUSY_DM), 2'(ARB_BUSY_DM), 2'(ARB_BUSY_IF)};
`else
      exp_q = '{2'(ARB_BUSY_DM), 2'(ARB_BUSY_DM), 2'(ARB_BUSY_DM),
                2'(ARB_BUSY_DM), 2'(ARB_BUSY_DM), 2'(ARB_BUSY_DM)};
`endif
      if_req = 1'b1; if_addr = 32'h40;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
      mem_ack = 1'b1;
      last_req = 1'b0;
      for (int i = 0; i < 18; i++) begin
         tick();
         if (mem_req && !last_req) got_q.push_back(2'(dbg_state));
         last_req = mem_req;
      end
      check_eq("starve_grant_count", 32'(got_q.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         logic [1:0] got;
         got = (got_q.size() != 0) ? got_q.pop_front() : 2'd3;
         check_eq($sformatf("starve_grant%0d", i), 32'(got), 32'(exp_q.pop_front()));
      end
      if_req = 1'b0; dm_req = 1'b0;
      repeat (4) tick();
      mem_ack = 1'b0;
      tick();
      check_eq("end_state", 32'(dbg_state), 32'(ARB_IDLE));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
